// File: rtl/mux_pkg.sv
// mux_pkg: shared defaults and select-width helper for the registered lane selector
package mux_pkg;
  localparam int N_IN_DEF = 4;
  localparam int DW_DEF = 1;
  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/mux_sel_core.sv
// mux_sel_core: combinational N_IN:1 lane selector, y = a[s*DW +: DW]
module mux_sel_core
  import mux_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int DW = DW_DEF,
  localparam int SEL_W = sel_w(N_IN)
) (
  input  logic [N_IN*DW-1:0] a,
  input  logic [SEL_W-1:0]   s,
  output logic [DW-1:0]      y
);
  logic [DW-1:0] w_lanes [N_IN];
  for (genvar k = 0; k < N_IN; k++) begin : g_lane
    assign w_lanes[k] = a[k*DW +: DW];
  end
  // N_IN is a power of two, so every select code names a real lane
  assign y = w_lanes[s];
endmodule

// File: rtl/mux4_registered.sv
// mux4_registered: lane selector with a load-enabled output register and valid flag
module mux4_registered
  import mux_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int DW = DW_DEF,
  localparam int SEL_W = sel_w(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN*DW-1:0] a,
  input  logic [SEL_W-1:0]  s,
  input  logic              en,
  output logic [DW-1:0]     o,
  output logic              o_valid,
  output logic [DW-1:0]     o_comb
);
  logic [DW-1:0] w_sel;
  logic [DW-1:0] r_o;
  logic          r_valid;
  mux_sel_core #(.N_IN(N_IN), .DW(DW)) u_core (
    .a(a),
    .s(s),
    .y(w_sel)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o     <= '0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_o     <= w_sel;
      r_valid <= 1'b1;
    end
  end
  assign o       = r_o;
  assign o_valid = r_valid;
  assign o_comb  = w_sel;
endmodule

// File: tb/tb_mux4_registered.sv
// tb_mux4_registered: randomized and directed checks of the 1-bit and 8-bit lane selectors
module tb_mux4_registered;
  logic        clk = 0;
  logic        rst = 0;
  logic [3:0]  a4 = 0;
  logic [1:0]  s4 = 0;
  logic        en4 = 0;
  logic        o4, v4, c4;
  logic [31:0] a8 = 0;
  logic [1:0]  s8 = 0;
  logic        en8 = 0;
  logic [7:0]  o8, c8;
  logic        v8;
  logic [7:0]  m_o4 = 0, m_o8 = 0;
  logic        m_v4 = 0, m_v8 = 0;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  mux4_registered u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .s(s4), .en(en4),
    .o(o4), .o_valid(v4), .o_comb(c4)
  );
  mux4_registered #(.N_IN(4), .DW(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .s(s8), .en(en8),
    .o(o8), .o_valid(v8), .o_comb(c8)
  );

  function automatic logic [7:0] lane(input logic [31:0] v, input int k, input int w);
    logic [31:0] t;
    t = v >> (k * w);
    return t[7:0] & 8'((1 << w) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_o4 = 0; m_v4 = 0; m_o8 = 0; m_v8 = 0;
    end else begin
      if (en4) begin m_o4 = lane({28'b0, a4}, int'(s4), 1); m_v4 = 1; end
      if (en8) begin m_o8 = lane(a8, int'(s8), 8); m_v8 = 1; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en4 = 1; a4 = 4'b1010; s4 = 2'b01;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++; if (o4 !== 1'b0) $display("FAIL reset_o got %b want 0", o4); else n_pass++;
      n_total++; if (v4 !== 1'b0) $display("FAIL reset_valid got %b want 0", v4); else n_pass++;
      n_total++; if (c4 !== 1'b1) $display("FAIL reset_comb got %b want 1", c4); else n_pass++;
    end
    rst = 0;
  endtask

  task automatic test_sweep(input logic [3:0] pat, input logic [3:0] want);
    a4 = pat; en4 = 1;
    for (int k = 0; k < 4; k++) begin
      s4 = 2'(k);
      #1;
      n_total++; if (c4 !== want[k]) $display("FAIL sweep_comb a=%b s=%0d got %b want %b", pat, k, c4, want[k]); else n_pass++;
      tick();
      n_total++; if (o4 !== want[k]) $display("FAIL sweep_o a=%b s=%0d got %b want %b", pat, k, o4, want[k]); else n_pass++;
      n_total++; if (v4 !== 1'b1) $display("FAIL sweep_valid got %b want 1", v4); else n_pass++;
    end
  endtask

  task automatic test_hold();
    a4 = 4'b1010; s4 = 2'b01; en4 = 1;
    tick();
    en4 = 0; s4 = 2'b00; a4 = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (o4 !== 1'b1) $display("FAIL hold_o got %b want 1", o4); else n_pass++;
      n_total++; if (v4 !== 1'b1) $display("FAIL hold_valid got %b want 1", v4); else n_pass++;
      n_total++; if (c4 !== 1'b0) $display("FAIL hold_comb got %b want 0", c4); else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    en4 = 1;
    for (int i = 0; i < 4; i++) begin
      a4 = 4'($urandom); s4 = 2'($urandom);
      tick();
    end
    a4 = 4'b1111; s4 = 2'b10; rst = 1;
    tick();
    n_total++; if (o4 !== 1'b0) $display("FAIL midrst_o got %b want 0", o4); else n_pass++;
    n_total++; if (v4 !== 1'b0) $display("FAIL midrst_valid got %b want 0", v4); else n_pass++;
    rst = 0; s4 = 2'b11; a4 = 4'b1000;
    tick();
    n_total++; if (o4 !== 1'b1) $display("FAIL midrst_reload_o got %b want 1", o4); else n_pass++;
    n_total++; if (v4 !== 1'b1) $display("FAIL midrst_reload_valid got %b want 1", v4); else n_pass++;
  endtask

  task automatic test_wide();
    logic [7:0] want [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    a8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; en8 = 1; en4 = 0;
    for (int k = 0; k < 4; k++) begin
      s8 = 2'(k);
      #1;
      n_total++; if (c8 !== want[k]) $display("FAIL wide_comb s=%0d got %h want %h", k, c8, want[k]); else n_pass++;
      tick();
      n_total++; if (o8 !== want[k]) $display("FAIL wide_o s=%0d got %h want %h", k, o8, want[k]); else n_pass++;
      n_total++; if (v8 !== 1'b1) $display("FAIL wide_valid got %b want 1", v8); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(15) == 0);
      en4 = 1'($urandom); en8 = 1'($urandom);
      a4 = 4'($urandom); s4 = 2'($urandom);
      a8 = $urandom; s8 = 2'($urandom);
      #1;
      n_total++; if ({7'b0, c4} !== lane({28'b0, a4}, int'(s4), 1)) $display("FAIL rand_comb4 i=%0d got %b a=%b s=%0d", i, c4, a4, s4); else n_pass++;
      n_total++; if (c8 !== lane(a8, int'(s8), 8)) $display("FAIL rand_comb8 i=%0d got %h want %h", i, c8, lane(a8, int'(s8), 8)); else n_pass++;
      tick();
      n_total++; if ({7'b0, o4} !== m_o4 || v4 !== m_v4) $display("FAIL rand_reg4 i=%0d got o=%b v=%b want o=%b v=%b", i, o4, v4, m_o4[0], m_v4); else n_pass++;
      n_total++; if (o8 !== m_o8 || v8 !== m_v8) $display("FAIL rand_reg8 i=%0d got o=%h v=%b want o=%h v=%b", i, o8, v8, m_o8, m_v8); else n_pass++;
    end
    rst = 0;
  endtask

  initial begin
    #2;
    test_reset();
    test_sweep(4'b1010, 4'b1010);
    test_hold();
    test_sweep(4'b0101, 4'b0101);
    test_mid_reset();
    test_wide();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
